// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus cycle arbiter.
// Contents: one-hot bus cycle state encoding, default address/data widths,
// and the wait counter width (sized for MAX_WAIT up to 255).
package bus_pkg;

    localparam int unsigned DEF_AW = 20;
    localparam int unsigned DEF_DW = 8;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
// Ports: req (pending requests), ptr (highest-priority index this round),
//        grant (one-hot winner), any_grant (some request present),
//        grant_idx (binary index of the winner).
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any_grant,
    output logic [PW-1:0]   grant_idx
);

    // Scan from ptr upward with wrap; first pending request wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        any_grant = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!any_grant && req[idx[PW-1:0]]) begin
                any_grant = 1'b1;
                grant_idx = idx[PW-1:0];
            end
        end
        grant = NREQ'(any_grant) << grant_idx;
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Shares one 8086-style multiplexed bus between NREQ requesters, running a
// T1-T2-T3-(TW)*-T4 cycle per transfer with READY-driven wait states and a
// wait-state timeout that ends the cycle with rsp_err.
// Ports: CLK/RESET; requester side req_* in, req_ready (combinational accept),
//        rsp_valid/rsp_rdata/rsp_err in T4; bus side ALE, RD_n, WR_n, IOM,
//        Address, Data_out, Data_oe out and Data_in, READY in.
module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ-1:0]    req_iom,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               ALE,
    output logic               RD_n,
    output logic               WR_n,
    output logic               IOM,
    output logic [AW-1:0]      Address,
    output logic [DW-1:0]      Data_out,
    output logic               Data_oe,
    input  logic [DW-1:0]      Data_in,
    input  logic               READY
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    bus_state_t          state;
    bus_state_t          next_state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       owner;
    logic                write_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [NREQ-1:0]     grant;
    logic                any_grant;
    logic [PW-1:0]       grant_idx;
    logic                take_c;
    logic                timeout_c;
    logic                strobe_next_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant),
        .grant_idx (grant_idx)
    );

    // Accept only when the bus is free (IDLE or the closing T4 cycle).
    assign take_c    = !RESET && any_grant && ((state == IDLE) || (state == T4));
    assign req_ready = take_c ? grant : '0;

    // Last allowed wait state still sees READY low.
    assign timeout_c = (state == TW) && !READY && (wait_cnt >= WAIT_W'(MAX_WAIT));

    assign strobe_next_c = (next_state == T2) || (next_state == T3) || (next_state == TW);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, T4: next_state = any_grant ? T1 : IDLE;
            T1:       next_state = T2;
            T2:       next_state = T3;
            T3:       next_state = READY ? T4 : TW;
            TW:       next_state = (READY || timeout_c) ? T4 : TW;
            default:  next_state = IDLE;
        endcase
    end

    // Payload capture, wait counter and registered bus/response outputs.
    // Outputs are decoded from next_state so they change cleanly with the state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr       <= '0;
            owner     <= '0;
            write_q   <= 1'b0;
            IOM       <= 1'b0;
            Address   <= '0;
            Data_out  <= '0;
            wait_cnt  <= '0;
            ALE       <= 1'b0;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            Data_oe   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (take_c) begin
                owner    <= grant_idx;
                write_q  <= req_write[grant_idx];
                IOM      <= req_iom[grant_idx];
                Address  <= req_addr[grant_idx*AW +: AW];
                Data_out <= req_wdata[grant_idx*DW +: DW];
                ptr      <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            wait_cnt  <= (next_state == TW) ? wait_cnt + 1'b1 : '0;
            ALE       <= (next_state == T1);
            RD_n      <= !(strobe_next_c && !write_q);
            WR_n      <= !(strobe_next_c && write_q);
            Data_oe   <= strobe_next_c && write_q;
            rsp_valid <= (next_state == T4) ? (NREQ'(1) << owner) : '0;
            rsp_err   <= (next_state == T4) && timeout_c;
            rsp_rdata <= ((next_state == T4) && READY && !write_q) ? Data_in : '0;
        end
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Scoreboard bench for bus_cycle_arbiter: directed cases plus randomized
// traffic against a timeline model of the bus cycle and a bus slave model.
module tb_bus_cycle_arbiter;

    localparam int NREQ     = 2;
    localparam int AW       = 20;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 15;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ-1:0]    req_iom = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               ALE, RD_n, WR_n, IOM, Data_oe;
    logic [AW-1:0]      Address;
    logic [DW-1:0]      Data_out;
    logic [DW-1:0]      Data_in = '0;
    logic               READY = 1'b1;

    bus_cycle_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_write(req_write), .req_iom(req_iom),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n), .IOM(IOM), .Address(Address),
        .Data_out(Data_out), .Data_oe(Data_oe), .Data_in(Data_in), .READY(READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit             write;
        bit             iom;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        int             gap;
        int             drop_after;
    } txn_t;

    typedef struct {
        int             owner;
        logic [DW-1:0]  rdata;
        bit             err;
        int             t4;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    txn_t rq[NREQ][$];
    int   wq[$];
    exp_t sb[$];

    txn_t cur[NREQ];
    bit   have[NREQ];
    int   gap_left[NREQ];
    int   acc_cyc[NREQ];
    logic [NREQ-1:0] rst_rv = '0;

    // Model of the transfer currently owning the bus.
    bit            active = 0;
    int            ptr_m = 0;
    int            k_g = 0, w_g = 0, n_g = 0;
    logic [DW-1:0] d_g = '0;
    bit            wr_g = 0, iom_g = 0;
    logic [AW-1:0] addr_g = '0;
    logic [DW-1:0] wdata_g = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int i);
        req_valid[i]            = 1'b1;
        req_write[i]            = cur[i].write;
        req_iom[i]              = cur[i].iom;
        req_addr[i*AW +: AW]    = cur[i].addr;
        req_wdata[i*DW +: DW]   = cur[i].wdata;
    endtask

    // Requester drivers and bus slave, updated just after each rising edge.
    always @(posedge CLK) begin
        int r;
        #1;
        if (RESET) begin
            req_valid = rst_rv;
            for (int i = 0; i < NREQ; i++) have[i] = 0;
            READY = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (have[i]) begin
                    if (req_valid[i]) begin
                        if (acc_cyc[i] == cyc - 1) begin
                            have[i] = 0;
                            req_valid[i] = 1'b0;
                        end else if (cur[i].drop_after == 0) begin
                            have[i] = 0;
                            req_valid[i] = 1'b0;
                        end else if (cur[i].drop_after > 0) begin
                            cur[i].drop_after = cur[i].drop_after - 1;
                        end
                    end else if (gap_left[i] > 0) begin
                        gap_left[i] = gap_left[i] - 1;
                    end else begin
                        drive(i);
                    end
                end
                if (!have[i] && rq[i].size() > 0) begin
                    cur[i]      = rq[i].pop_front();
                    have[i]     = 1;
                    gap_left[i] = cur[i].gap;
                    if (gap_left[i] == 0) drive(i);
                end
            end
            // Slave: READY low for w_g cycles from T3, data presented on the ready cycle.
            r = cyc - k_g;
            if (active && r >= 3 && r < 3 + w_g)  READY = 1'b0;
            else if (active && r == 3 + w_g)      READY = 1'b1;
            else                                  READY = 1'($urandom_range(0, 1));
            Data_in = (active && r == 3 + w_g) ? d_g : DW'($urandom);
        end
    end

    // Monitor: bus pin timeline, response scoreboard and grant prediction.
    always @(negedge CLK) begin
        int r, g, n, w;
        bit inx, stb, free;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        if (RESET) begin
            sb.delete();
            active = 0;
            ptr_m  = 0;
            for (int j = 0; j < NREQ; j++) acc_cyc[j] = -10;
        end else begin
            r   = cyc - k_g;
            inx = active && r >= 1 && r <= 4 + n_g;
            stb = inx && r >= 2 && r <= 3 + n_g;
            chk("ale", 32'(ALE), 32'(inx && r == 1));
            chk("rd_n", 32'(RD_n), 32'(!(stb && !wr_g)));
            chk("wr_n", 32'(WR_n), 32'(!(stb && wr_g)));
            chk("data_oe", 32'(Data_oe), 32'(stb && wr_g));
            if (inx) begin
                chk("address", 32'(Address), 32'(addr_g));
                chk("iom", 32'(IOM), 32'(iom_g));
            end
            if (stb && wr_g) chk("data_out", 32'(Data_out), 32'(wdata_g));

            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.owner);
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_cycle", 32'(cyc), 32'(e.t4));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].t4) begin
                e = sb.pop_front();
                chk("rsp_missing", 32'(0), 32'(1) << e.owner);
            end

            g    = -1;
            free = !active || r >= 4 + n_g;
            if (free) begin
                for (int j = 0; j < NREQ; j++) begin
                    int idx;
                    idx = (ptr_m + j) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));

            if (g >= 0) begin
                if (wq.size() > 0) w = wq.pop_front();
                else if ($urandom_range(0, 9) == 0) w = int'($urandom_range(13, 18));
                else w = int'($urandom_range(0, 3));
                n          = (w > MAX_WAIT) ? MAX_WAIT : w;
                acc_cyc[g] = cyc;
                ptr_m      = (g + 1) % NREQ;
                k_g        = cyc;
                w_g        = w;
                n_g        = n;
                d_g        = DW'($urandom);
                wr_g       = cur[g].write;
                iom_g      = cur[g].iom;
                addr_g     = cur[g].addr;
                wdata_g    = cur[g].wdata;
                active     = 1;
                e.owner    = g;
                e.err      = (w > MAX_WAIT);
                e.rdata    = (!cur[g].write && !e.err) ? d_g : '0;
                e.t4       = cyc + 4 + n;
                sb.push_back(e);
            end
        end
    end

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || have[0] || have[1] || sb.size() > 0)
               && t < budget) begin
            @(posedge CLK);
            t++;
        end
        chk("drain_timeout", 32'(t >= budget), 32'(0));
        repeat (3) @(posedge CLK);
    endtask

    function automatic txn_t mk(input bit wr, input bit io, input int a, input int d,
                                input int gap, input int drop);
        txn_t t;
        t.write = wr; t.iom = io; t.addr = AW'(a); t.wdata = DW'(d);
        t.gap = gap; t.drop_after = drop;
        return t;
    endfunction

    initial begin
        int t;
        // Reset values, with both requests asserted during reset.
        rst_rv = '1;
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_ale", 32'(ALE), 0);
        chk("rst_rd_n", 32'(RD_n), 1);
        chk("rst_wr_n", 32'(WR_n), 1);
        chk("rst_iom", 32'(IOM), 0);
        chk("rst_address", 32'(Address), 0);
        chk("rst_data_out", 32'(Data_out), 0);
        chk("rst_data_oe", 32'(Data_oe), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        rst_rv = '0;
        @(posedge CLK);
        #2 RESET = 1'b0;

        // Single zero-wait read.
        rq[0].push_back(mk(0, 0, 'h12345, 0, 0, -1));
        wq.push_back(0);
        wait_done(100);

        // IO write with three wait states.
        rq[1].push_back(mk(1, 1, 'h0060, 'hA5, 0, -1));
        wq.push_back(3);
        wait_done(100);

        // READY stuck low: timeout.
        rq[0].push_back(mk(0, 0, 'h0BEEF, 0, 0, -1));
        wq.push_back(MAX_WAIT + 5);
        wait_done(100);

        // Both requesters continuously valid: alternating grants, T4 straight to T1.
        for (int i = 0; i < 4; i++) begin
            rq[0].push_back(mk(i % 2 == 1, 0, 'h100 + i, 'h10 + i, 0, -1));
            rq[1].push_back(mk(i % 2 == 0, 1, 'h200 + i, 'h20 + i, 0, -1));
            wq.push_back(i);
            wq.push_back(0);
        end
        wait_done(300);

        // Requester 1 withdraws while 0 is busy; then 1 should win next round.
        rq[0].push_back(mk(0, 0, 'h33333, 0, 0, -1));
        rq[1].push_back(mk(1, 0, 'h44444, 'h5A, 1, 2));
        wq.push_back(4);
        wait_done(100);
        rq[0].push_back(mk(1, 0, 'h55555, 'h3C, 0, -1));
        rq[1].push_back(mk(0, 1, 'h00066, 0, 0, -1));
        wait_done(100);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int q;
            q = int'($urandom_range(0, NREQ - 1));
            rq[q].push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               int'($urandom), int'($urandom), int'($urandom_range(0, 3)),
                               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1));
        end
        wait_done(3000);

        // Reset in the middle of a wait-stated read.
        rq[0].push_back(mk(0, 0, 'h0ABCD, 0, 0, -1));
        wq.push_back(10);
        t = 0;
        @(posedge CLK);
        #2;
        while (!(active && cyc == k_g + 6) && t < 100) begin
            @(posedge CLK);
            #2;
            t++;
        end
        chk("reach_tw_timeout", 32'(t >= 100), 0);
        #1 RESET = 1'b1;
        #1;
        chk("midrst_rd_n", 32'(RD_n), 1);
        chk("midrst_wr_n", 32'(WR_n), 1);
        chk("midrst_ale", 32'(ALE), 0);
        chk("midrst_data_oe", 32'(Data_oe), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_address", 32'(Address), 0);
        wq.delete();
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b0;
        repeat (10) @(posedge CLK);

        // After reset the pointer restarts at requester 0.
        rq[1].push_back(mk(0, 0, 'h77777, 0, 0, -1));
        rq[0].push_back(mk(1, 1, 'h00088, 'hC3, 0, -1));
        wait_done(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
